// File: rtl/ad9228_sample_packer.sv
// Packs 12-bit AD9228 samples densely into 32-bit words and queues them in a FWFT FIFO for AXI-stream.
// Optional macro AD9228_PACKER_TEST_PATTERN_EN adds test_mode, which substitutes a counter for the samples.
module ad9228_sample_packer #(
  parameter int DATA_WIDTH  = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 96
) (
  input  logic                          dco_div4,
  input  logic                          rstn,
  input  logic                          enable,
`ifdef AD9228_PACKER_TEST_PATTERN_EN
  input  logic                          test_mode,
`endif
  input  logic [DATA_WIDTH-1:0]         des_data,
  input  logic                          des_data_valid,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ACC_W = 44;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int FCW   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  if (DATA_WIDTH != 12) begin : g_bad_width
    $error("ad9228_sample_packer: DATA_WIDTH must be 12");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ad9228_sample_packer: FIFO_DEPTH must be a power of 2 and at least 4");
  end
  if (FRAME_WORDS < 1) begin : g_bad_frame
    $error("ad9228_sample_packer: FRAME_WORDS must be at least 1");
  end

  logic [DATA_WIDTH-1:0] sample;

`ifdef AD9228_PACKER_TEST_PATTERN_EN
  logic [11:0] tp_cnt_q, tp_cnt_d;

  always_comb begin
    tp_cnt_d = tp_cnt_q;
    if (!enable)             tp_cnt_d = '0;
    else if (des_data_valid) tp_cnt_d = tp_cnt_q + 12'd1;
  end

  always_ff @(posedge dco_div4 or negedge rstn) begin
    if (!rstn) tp_cnt_q <= '0;
    else       tp_cnt_q <= tp_cnt_d;
  end

  assign sample = test_mode ? tp_cnt_q : des_data;
`else
  assign sample = des_data;
`endif

  // Packing state and one-word pipeline register in front of the FIFO.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]      wrd_data_q, wrd_data_d;
  logic             wrd_last_q, wrd_last_d;
  logic             wrd_valid_q, wrd_valid_d;
  logic [ACC_W-1:0] merged;
  logic [5:0]       cnt_sum;
  logic             frame_end;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    wrd_data_d  = wrd_data_q;
    wrd_last_d  = wrd_last_q;
    wrd_valid_d = 1'b0;
    merged      = acc_q | ({{(ACC_W-DATA_WIDTH){1'b0}}, sample} << cnt_q);
    cnt_sum     = {1'b0, cnt_q} + 6'd12;
    frame_end   = (frame_cnt_q == FCW'(FRAME_WORDS - 1));
    if (!enable) begin
      acc_d       = '0;
      cnt_d       = '0;
      frame_cnt_d = '0;
    end else if (des_data_valid) begin
      if (cnt_sum >= 6'd32) begin
        wrd_valid_d = 1'b1;
        wrd_data_d  = merged[31:0];
        wrd_last_d  = frame_end;
        frame_cnt_d = frame_end ? '0 : frame_cnt_q + 1'b1;
        acc_d       = {32'b0, merged[ACC_W-1:32]};
        cnt_d       = 5'(cnt_sum - 6'd32);
      end else begin
        acc_d = merged;
        cnt_d = cnt_sum[4:0];
      end
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head is popped in the same cycle.
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, do_write;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [32:0]   head;

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign pop      = m_tvalid & m_tready;
  assign do_write = wrd_valid_q & (~full | pop);

  always_comb begin
    wr_ptr_d = do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop      ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({do_write, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d = clear_overflow ? 1'b0 : ovf_q;
    if (wrd_valid_q && full && !pop) ovf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge dco_div4 or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      wrd_data_q  <= '0;
      wrd_last_q  <= 1'b0;
      wrd_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      wrd_data_q  <= wrd_data_d;
      wrd_last_q  <= wrd_last_d;
      wrd_valid_q <= wrd_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: the storage array is not reset; emptiness is tracked by level_q and the outputs are gated by it.
  always_ff @(posedge dco_div4) begin
    if (do_write) mem[wr_ptr_q] <= {wrd_last_q, wrd_data_q};
  end

  assign head       = mem[rd_ptr_q];
  assign m_tvalid   = (level_q != '0);
  assign m_tdata    = m_tvalid ? head[31:0] : 32'h0;
  assign m_tlast    = m_tvalid & head[32];
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule
